// File: rtl/slow_adc_responder_if.sv
// rtl/slow_adc_responder_if.sv - host-facing serial pins of the slow ADC responder
interface slow_adc_responder_if;
   logic CNV_in;
   logic CS_in;
   logic SCKI_in;
   logic SDI_in;
   logic BUSY_out;
   logic SDO_out;
   logic SCKO_out;

   modport master (
      output CNV_in, CS_in, SCKI_in, SDI_in,
      input  BUSY_out, SDO_out, SCKO_out
   );

   modport slave (
      input  CNV_in, CS_in, SCKI_in, SDI_in,
      output BUSY_out, SDO_out, SCKO_out
   );
endinterface

// File: rtl/slow_adc_responder.sv
// rtl/slow_adc_responder.sv - emulated multi-channel SPI ADC with conversion busy timing
module slow_adc_responder #(
   parameter int N_BUSY = 45,
   parameter int N_WORD = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   slow_adc_responder_if.slave      bus,
   input  logic signed [15:0]       ch_data [0:7],
   output logic [23:0]              cfg_out,
   output logic                     cfg_valid,
   output logic [2:0]               ch_ptr_out
);

   localparam int BW = (N_BUSY > 1) ? $clog2(N_BUSY) : 1;
   localparam int CW = $clog2(N_WORD + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_READY,
      S_SHIFT
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // synchronizer stages plus one history flop per line for edge detection
   logic r_cnv_s1, r_cnv_s2, r_cnv_d;
   logic r_cs_s1,  r_cs_s2,  r_cs_d;
   logic r_sck_s1, r_sck_s2, r_sck_d;
   logic r_sdi_s1, r_sdi_s2;

   logic [BW-1:0] r_busy_cnt;
   logic [23:0]   r_shift;
   logic [23:0]   r_cap;
   logic [CW-1:0] r_bit_cnt;
   logic [23:0]   r_cfg;
   logic          r_cfg_valid;
   logic [2:0]    r_ch_ptr;
   logic          r_scko;

   logic w_cnv_rise;
   logic w_cs_rise;
   logic w_sck_rise;
   logic w_sck_fall;
   logic w_word_done;
   logic w_start_conv;
   logic w_load_word;
   logic w_start_shift;
   logic w_commit;

   // bring the asynchronous host pins into the clk domain; idle levels on reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnv_s1 <= 1'b0; r_cnv_s2 <= 1'b0; r_cnv_d <= 1'b0;
         r_cs_s1  <= 1'b1; r_cs_s2  <= 1'b1; r_cs_d  <= 1'b1;
         r_sck_s1 <= 1'b0; r_sck_s2 <= 1'b0; r_sck_d <= 1'b0;
         r_sdi_s1 <= 1'b0; r_sdi_s2 <= 1'b0;
      end else begin
         r_cnv_s1 <= bus.CNV_in;  r_cnv_s2 <= r_cnv_s1; r_cnv_d <= r_cnv_s2;
         r_cs_s1  <= bus.CS_in;   r_cs_s2  <= r_cs_s1;  r_cs_d  <= r_cs_s2;
         r_sck_s1 <= bus.SCKI_in; r_sck_s2 <= r_sck_s1; r_sck_d <= r_sck_s2;
         r_sdi_s1 <= bus.SDI_in;  r_sdi_s2 <= r_sdi_s1;
      end
   end

   // serial clock edges only count while the host holds chip select low
   assign w_cnv_rise  = r_cnv_s2 & ~r_cnv_d;
   assign w_cs_rise   = r_cs_s2 & ~r_cs_d;
   assign w_sck_rise  = r_sck_s2 & ~r_sck_d & ~r_cs_s2;
   assign w_sck_fall  = ~r_sck_s2 & r_sck_d & ~r_cs_s2;
   assign w_word_done = (r_bit_cnt == CW'(N_WORD));

   // state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state and datapath strobes; a conversion start outranks any chip-select event
   always_comb begin
      w_state_nxt   = r_state;
      w_start_conv  = 1'b0;
      w_load_word   = 1'b0;
      w_start_shift = 1'b0;
      w_commit      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cnv_rise) begin
               w_state_nxt  = S_CONV;
               w_start_conv = 1'b1;
            end
         end
         S_CONV: begin
            if (r_busy_cnt == '0) begin
               w_state_nxt = S_READY;
               w_load_word = 1'b1;
            end
         end
         S_READY: begin
            if (w_cnv_rise) begin
               w_state_nxt  = S_CONV;
               w_start_conv = 1'b1;
            end else if (!r_cs_s2) begin
               w_state_nxt   = S_SHIFT;
               w_start_shift = 1'b1;
            end
         end
         S_SHIFT: begin
            if (w_cnv_rise) begin
               w_state_nxt  = S_CONV;
               w_start_conv = 1'b1;
            end else if (w_cs_rise) begin
               w_state_nxt = S_IDLE;
               w_commit    = w_word_done;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // busy timer, result shifter, config capture and channel pointer
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_busy_cnt  <= '0;
         r_shift     <= '0;
         r_cap       <= '0;
         r_bit_cnt   <= '0;
         r_cfg       <= '0;
         r_cfg_valid <= 1'b0;
         r_ch_ptr    <= '0;
         r_scko      <= 1'b0;
      end else begin
         r_cfg_valid <= w_commit;
         r_scko      <= r_sck_s2 & ~r_cs_s2;

         if (w_start_conv) begin
            r_busy_cnt <= BW'(N_BUSY - 1);
         end else if (r_state == S_CONV && r_busy_cnt != '0) begin
            r_busy_cnt <= r_busy_cnt - 1'b1;
         end

         // once the full word has been clocked the line drains to zero
         if (w_load_word) begin
            r_shift <= {ch_data[r_ch_ptr], r_ch_ptr, 5'b0};
         end else if (r_state == S_SHIFT && w_sck_fall) begin
            r_shift <= w_word_done ? '0 : {r_shift[22:0], 1'b0};
         end

         if (w_start_shift) begin
            r_cap     <= '0;
            r_bit_cnt <= '0;
         end else if (r_state == S_SHIFT && w_sck_rise && !w_word_done) begin
            r_cap     <= {r_cap[22:0], r_sdi_s2};
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end

         if (w_commit) begin
            r_cfg    <= r_cap;
            r_ch_ptr <= r_ch_ptr + 1'b1;
         end
      end
   end

   assign bus.BUSY_out = (r_state == S_CONV);
   assign bus.SDO_out  = (r_state == S_SHIFT) ? r_shift[23] : 1'b0;
   assign bus.SCKO_out = r_scko;
   assign cfg_out      = r_cfg;
   assign cfg_valid    = r_cfg_valid;
   assign ch_ptr_out   = r_ch_ptr;

endmodule

// File: tb/tb_slow_adc_responder.sv
// tb/tb_slow_adc_responder.sv - self-checking bench for slow_adc_responder
module tb_slow_adc_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   slow_adc_responder_if bus();

   logic signed [15:0] ch_data [0:7];
   logic [23:0] cfg_out;
   logic        cfg_valid;
   logic [2:0]  ch_ptr_out;

   slow_adc_responder #(.N_BUSY(45), .N_WORD(24)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .ch_data    (ch_data),
      .cfg_out    (cfg_out),
      .cfg_valid  (cfg_valid),
      .ch_ptr_out (ch_ptr_out)
   );

   int checks = 0;
   int errors = 0;
   int vcnt   = 0;

   // count clock cycles with cfg_valid high
   always @(posedge clk) if (cfg_valid) vcnt <= vcnt + 1;

   // reference model state
   int          m_ptr = 0;
   logic [23:0] m_cfg = '0;
   logic        g_scko_hi;

   typedef struct {
      logic [15:0] chv;
      logic [23:0] sdi;
      int          n;
      logic [23:0] exp_word;
      logic [23:0] exp_cfg;
      int          exp_pulses;
      logic [2:0]  exp_ptr;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // what the host should have sampled for n clocks of a 24-bit word
   function automatic logic [31:0] exp_smp(input logic [23:0] w, input int n);
      if (n >= 24) return 32'(w) << (n - 24);
      return 32'(w) >> (24 - n);
   endfunction

   function automatic logic [31:0] smp_mask(input int n);
      if (n >= 32) return '1;
      return (32'd1 << n) - 32'd1;
   endfunction

   task automatic do_conv(input int retrig_at, output int busy_len);
      int t;
      busy_len = 0;
      t = 0;
      bus.CNV_in = 1'b1;
      while (!bus.BUSY_out && t < 20) begin cyc(1); t++; end
      bus.CNV_in = 1'b0;
      chk("busy_rise", bus.BUSY_out, 1);
      t = 0;
      while (bus.BUSY_out && t < 200) begin
         if (t == retrig_at)     bus.CNV_in = 1'b1;
         if (t == retrig_at + 3) bus.CNV_in = 1'b0;
         busy_len++;
         cyc(1);
         t++;
      end
      bus.CNV_in = 1'b0;
   endtask

   task automatic do_shift(input logic [23:0] sdi, input int n, output logic [31:0] smp);
      logic [23:0] s;
      s   = sdi;
      smp = '0;
      bus.CS_in = 1'b0;
      cyc(4);
      for (int i = 0; i < n; i++) begin
         bus.SDI_in = s[23];
         s = {s[22:0], 1'b1};
         cyc(4);
         smp = {smp[30:0], bus.SDO_out};
         bus.SCKI_in = 1'b1;
         cyc(4);
         if (i == 0) g_scko_hi = bus.SCKO_out;
         bus.SCKI_in = 1'b0;
      end
      cyc(4);
   endtask

   task automatic do_release(output int pulses);
      int v0;
      v0 = vcnt;
      bus.CS_in = 1'b1;
      cyc(8);
      pulses = vcnt - v0;
   endtask

   // one full conversion + transfer checked against the model
   task automatic xact(input string tag, input logic [23:0] sdi, input int n, input int retrig);
      int bl, pulses;
      logic [31:0] smp;
      logic [23:0] expw;
      expw = {ch_data[m_ptr], 3'(m_ptr), 5'b0};
      do_conv(retrig, bl);
      chk($sformatf("%s_busy_len", tag), bl, 45);
      do_shift(sdi, n, smp);
      chk($sformatf("%s_sdo", tag), smp & smp_mask(n), exp_smp(expw, n));
      do_release(pulses);
      if (n >= 24) begin
         m_cfg = sdi;
         m_ptr = (m_ptr + 1) % 8;
      end
      chk($sformatf("%s_valid", tag), pulses, (n >= 24) ? 1 : 0);
      chk($sformatf("%s_cfg", tag), cfg_out, m_cfg);
      chk($sformatf("%s_ptr", tag), ch_ptr_out, m_ptr);
   endtask

   initial begin
      int bl, pulses, t, v0;
      logic [31:0] smp;

      tbl[0] = '{16'h8001, 24'hA5C3F0, 24, 24'h800100, 24'hA5C3F0, 1, 3'd1};
      tbl[1] = '{16'h1234, 24'h123456, 10, 24'h123420, 24'hA5C3F0, 0, 3'd1};
      tbl[2] = '{16'hFFFF, 24'h000001, 24, 24'hFFFF20, 24'h000001, 1, 3'd2};
      tbl[3] = '{16'h7FFE, 24'h5A0F3C, 26, 24'h7FFE40, 24'h5A0F3C, 1, 3'd3};

      rst = 1'b0;
      bus.CNV_in = 1'b0; bus.CS_in = 1'b1; bus.SCKI_in = 1'b0; bus.SDI_in = 1'b0;
      for (int k = 0; k < 8; k++) ch_data[k] = '0;
      cyc(3);
      chk("rst_busy", bus.BUSY_out, 0);
      chk("rst_sdo", bus.SDO_out, 0);
      chk("rst_scko", bus.SCKO_out, 0);
      chk("rst_cfg", cfg_out, 0);
      chk("rst_valid", cfg_valid, 0);
      chk("rst_ptr", ch_ptr_out, 0);
      rst = 1'b1;
      cyc(2);

      // table vectors
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < 8; k++) ch_data[k] = tbl[v].chv;
         do_conv(-1, bl);
         chk($sformatf("tbl%0d_busy_len", v), bl, 45);
         do_shift(tbl[v].sdi, tbl[v].n, smp);
         chk($sformatf("tbl%0d_sdo", v), smp & smp_mask(tbl[v].n), exp_smp(tbl[v].exp_word, tbl[v].n));
         chk($sformatf("tbl%0d_scko", v), g_scko_hi, 1);
         do_release(pulses);
         chk($sformatf("tbl%0d_valid", v), pulses, tbl[v].exp_pulses);
         chk($sformatf("tbl%0d_cfg", v), cfg_out, tbl[v].exp_cfg);
         chk($sformatf("tbl%0d_ptr", v), ch_ptr_out, tbl[v].exp_ptr);
      end
      m_cfg = tbl[3].exp_cfg;
      m_ptr = int'(tbl[3].exp_ptr);

      // serial clock with chip select high is ignored
      for (int i = 0; i < 3; i++) begin
         bus.SCKI_in = 1'b1; cyc(4);
         chk("cs_high_scko", bus.SCKO_out, 0);
         chk("idle_sdo", bus.SDO_out, 0);
         bus.SCKI_in = 1'b0; cyc(4);
      end
      chk("cs_high_ptr", ch_ptr_out, m_ptr);

      // second CNV ten cycles into the conversion does not restart it
      xact("retrig", 24'h0F0F0F, 24, 10);

      // CNV during a transfer aborts it and starts a new conversion
      v0 = vcnt;
      do_conv(-1, bl);
      chk("abort_busy_len", bl, 45);
      do_shift(24'hDEADBE, 5, smp);
      bus.CNV_in = 1'b1;
      cyc(4);
      chk("abort_busy_rise", bus.BUSY_out, 1);
      bus.CNV_in = 1'b0;
      bus.CS_in = 1'b1;
      t = 0;
      while (bus.BUSY_out && t < 100) begin cyc(1); t++; end
      chk("abort_busy_fall", bus.BUSY_out, 0);
      cyc(4);
      chk("abort_no_valid", vcnt - v0, 0);
      chk("abort_cfg", cfg_out, m_cfg);
      chk("abort_ptr", ch_ptr_out, m_ptr);

      // nine conversions walking every channel and wrapping
      for (int k = 0; k < 8; k++) ch_data[k] = 16'(k * 16'h1111);
      for (int j = 0; j < 9; j++) xact($sformatf("walk%0d", j), 24'(j * 24'h010203), 24, -1);

      // randomized transfers
      for (int j = 0; j < 10; j++) begin
         int n;
         for (int k = 0; k < 8; k++) ch_data[k] = 16'($urandom);
         n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 23)) : 24;
         xact($sformatf("rnd%0d", j), 24'($urandom), n, -1);
      end

      // reset in the middle of a transfer
      v0 = vcnt;
      do_conv(-1, bl);
      do_shift(24'h13579B, 12, smp);
      bus.SCKI_in = 1'b1;
      cyc(4);
      rst = 1'b0;
      cyc(1);
      chk("mid_rst_busy", bus.BUSY_out, 0);
      chk("mid_rst_sdo", bus.SDO_out, 0);
      chk("mid_rst_scko", bus.SCKO_out, 0);
      chk("mid_rst_cfg", cfg_out, 0);
      chk("mid_rst_valid", cfg_valid, 0);
      chk("mid_rst_ptr", ch_ptr_out, 0);
      bus.SCKI_in = 1'b0;
      bus.CS_in = 1'b1;
      rst = 1'b1;
      cyc(6);
      chk("mid_rst_no_valid", vcnt - v0, 0);
      m_ptr = 0;
      m_cfg = '0;
      for (int k = 0; k < 8; k++) ch_data[k] = 16'(16'h0101 * (k + 1));
      xact("post_rst", 24'hC0FFEE, 24, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
